// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-level 2:1 arbiter feeding the 10G MAC TX AXI-Stream
// path from the ARP and IP/UDP transmitters. Whole frames are granted, never
// interleaved. One registered output stage gives 1-cycle input-to-output latency.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | no grant; arbitrate between pending sources (no beats taken)
// ST_GNT_ARP   | ARP owns the output, beats forwarded
// ST_GNT_IP    | IP owns the output, beats forwarded
// ST_DROP_ARP  | ARP frame was force-terminated; swallow beats up to its last
// ST_DROP_IP   | IP frame was force-terminated; swallow beats up to its last

module mac_tx_arbiter #(
  parameter int P_ARP_PRIORITY = 1,
  parameter int P_MAX_BEATS    = 1500
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic [63:0] s_axis_arp_data,
  input  logic [79:0] s_axis_arp_user,
  input  logic [7:0]  s_axis_arp_keep,
  input  logic        s_axis_arp_last,
  input  logic        s_axis_arp_valid,
  output logic        s_axis_arp_ready,

  input  logic [63:0] s_axis_ip_data,
  input  logic [79:0] s_axis_ip_user,
  input  logic [7:0]  s_axis_ip_keep,
  input  logic        s_axis_ip_last,
  input  logic        s_axis_ip_valid,
  output logic        s_axis_ip_ready,

  output logic [63:0] m_axis_mac_data,
  output logic [79:0] m_axis_mac_user,
  output logic [7:0]  m_axis_mac_keep,
  output logic        m_axis_mac_last,
  output logic        m_axis_mac_valid,
  input  logic        m_axis_mac_ready,

  output logic        o_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GNT_ARP  = 3'd1,
    ST_GNT_IP   = 3'd2,
    ST_DROP_ARP = 3'd3,
    ST_DROP_IP  = 3'd4
  } state_t;

  localparam logic [10:0] L_MAX_BEATS = 11'(P_MAX_BEATS);
  localparam logic        L_ARP_PRIO  = (P_ARP_PRIORITY != 0);

  state_t      state_q, state_d;
  // Round-robin pointer: 0 = ARP goes next, 1 = IP goes next.
  logic        rr_q, rr_d;
  logic [10:0] beat_cnt_q, beat_cnt_d;

  logic [63:0] data_q, data_d;
  logic [79:0] user_q, user_d;
  logic [7:0]  keep_q, keep_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  logic        src_arp;
  logic        out_free;
  logic        arp_rdy;
  logic        ip_rdy;
  logic        accept;
  logic        in_last;
  logic [63:0] in_data;
  logic [79:0] in_user;
  logic [7:0]  in_keep;
  logic [10:0] beat_cnt_inc;
  logic        limit_hit;

  // Decode which source is selected and whether its current beat is taken.
  // Readies are held low while reset is asserted so no beat is consumed then.
  always_comb begin
    src_arp  = (state_q == ST_GNT_ARP) || (state_q == ST_DROP_ARP);
    out_free = !valid_q || m_axis_mac_ready;
    arp_rdy  = !i_rst && (((state_q == ST_GNT_ARP) && out_free) || (state_q == ST_DROP_ARP));
    ip_rdy   = !i_rst && (((state_q == ST_GNT_IP) && out_free) || (state_q == ST_DROP_IP));
    in_data  = src_arp ? s_axis_arp_data : s_axis_ip_data;
    in_user  = src_arp ? s_axis_arp_user : s_axis_ip_user;
    in_keep  = src_arp ? s_axis_arp_keep : s_axis_ip_keep;
    in_last  = src_arp ? s_axis_arp_last : s_axis_ip_last;
    accept   = src_arp ? (s_axis_arp_valid && arp_rdy) : (s_axis_ip_valid && ip_rdy);
    beat_cnt_inc = beat_cnt_q + 11'd1;
    limit_hit    = (beat_cnt_inc == L_MAX_BEATS);
  end

  // Next-state logic: arbitration, frame tracking, length limit, output stage
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    user_d     = user_q;
    keep_d     = keep_q;
    last_d     = last_q;
    valid_d    = valid_q;
    ovr_d      = 1'b0;

    // A consumed output beat empties the register unless reloaded below.
    if (m_axis_mac_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_axis_arp_valid && s_axis_ip_valid) begin
          state_d = (L_ARP_PRIO || !rr_q) ? ST_GNT_ARP : ST_GNT_IP;
        end else if (s_axis_arp_valid) begin
          state_d = ST_GNT_ARP;
        end else if (s_axis_ip_valid) begin
          state_d = ST_GNT_IP;
        end
      end

      ST_GNT_ARP, ST_GNT_IP: begin
        if (accept) begin
          data_d  = in_data;
          user_d  = in_user;
          keep_d  = in_keep;
          last_d  = in_last || limit_hit;
          valid_d = 1'b1;
          if (in_last) begin
            state_d    = ST_IDLE;
            rr_d       = src_arp;
            beat_cnt_d = 11'd0;
          end else if (limit_hit) begin
            // Close the frame at the MAC and swallow the rest of it upstream.
            state_d    = src_arp ? ST_DROP_ARP : ST_DROP_IP;
            ovr_d      = 1'b1;
            beat_cnt_d = 11'd0;
          end else begin
            beat_cnt_d = beat_cnt_inc;
          end
        end
      end

      ST_DROP_ARP, ST_DROP_IP: begin
        if (accept && in_last) begin
          state_d    = ST_IDLE;
          rr_d       = src_arp;
          beat_cnt_d = 11'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and output register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      beat_cnt_q <= 11'd0;
      data_q     <= 64'd0;
      user_q     <= 80'd0;
      keep_q     <= 8'd0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      user_q     <= user_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign s_axis_arp_ready = arp_rdy;
  assign s_axis_ip_ready  = ip_rdy;
  assign m_axis_mac_data  = data_q;
  assign m_axis_mac_user  = user_q;
  assign m_axis_mac_keep  = keep_q;
  assign m_axis_mac_last  = last_q;
  assign m_axis_mac_valid = valid_q;
  assign o_overrun        = ovr_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter. Two instances share one stimulus bus:
// u_dut_pri (ARP priority, full frame limit) and u_dut_rr (round-robin, limit
// of 4 beats). sel picks which instance's outputs the source/sink models follow.

module tb_mac_tx_arbiter;

  typedef struct packed {
    logic [63:0] d;
    logic [79:0] u;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic  av, ar, iv, ir, mv, mr, ov;
    beat_t ob;
  } trace_t;

  logic        clk;
  logic        i_rst;
  logic [63:0] arp_data, ip_data;
  logic [79:0] arp_user, ip_user;
  logic [7:0]  arp_keep, ip_keep;
  logic        arp_last, ip_last, arp_valid, ip_valid, m_ready;

  logic        a_arp_ready, a_ip_ready, a_mv, a_ml, a_ovr;
  logic [63:0] a_md;
  logic [79:0] a_mu;
  logic [7:0]  a_mk;
  logic        b_arp_ready, b_ip_ready, b_mv, b_ml, b_ovr;
  logic [63:0] b_md;
  logic [79:0] b_mu;
  logic [7:0]  b_mk;

  logic        sel;
  logic        arp_ready, ip_ready, mv, ml, ovr;
  logic [63:0] md;
  logic [79:0] mu;
  logic [7:0]  mk;

  assign arp_ready = sel ? b_arp_ready : a_arp_ready;
  assign ip_ready  = sel ? b_ip_ready  : a_ip_ready;
  assign mv        = sel ? b_mv  : a_mv;
  assign ml        = sel ? b_ml  : a_ml;
  assign ovr       = sel ? b_ovr : a_ovr;
  assign md        = sel ? b_md  : a_md;
  assign mu        = sel ? b_mu  : a_mu;
  assign mk        = sel ? b_mk  : a_mk;

  mac_tx_arbiter #(.P_ARP_PRIORITY(1), .P_MAX_BEATS(1500)) u_dut_pri (
    .i_clk(clk), .i_rst(i_rst),
    .s_axis_arp_data(arp_data), .s_axis_arp_user(arp_user), .s_axis_arp_keep(arp_keep),
    .s_axis_arp_last(arp_last), .s_axis_arp_valid(arp_valid), .s_axis_arp_ready(a_arp_ready),
    .s_axis_ip_data(ip_data), .s_axis_ip_user(ip_user), .s_axis_ip_keep(ip_keep),
    .s_axis_ip_last(ip_last), .s_axis_ip_valid(ip_valid), .s_axis_ip_ready(a_ip_ready),
    .m_axis_mac_data(a_md), .m_axis_mac_user(a_mu), .m_axis_mac_keep(a_mk),
    .m_axis_mac_last(a_ml), .m_axis_mac_valid(a_mv), .m_axis_mac_ready(m_ready),
    .o_overrun(a_ovr)
  );

  mac_tx_arbiter #(.P_ARP_PRIORITY(0), .P_MAX_BEATS(4)) u_dut_rr (
    .i_clk(clk), .i_rst(i_rst),
    .s_axis_arp_data(arp_data), .s_axis_arp_user(arp_user), .s_axis_arp_keep(arp_keep),
    .s_axis_arp_last(arp_last), .s_axis_arp_valid(arp_valid), .s_axis_arp_ready(b_arp_ready),
    .s_axis_ip_data(ip_data), .s_axis_ip_user(ip_user), .s_axis_ip_keep(ip_keep),
    .s_axis_ip_last(ip_last), .s_axis_ip_valid(ip_valid), .s_axis_ip_ready(b_ip_ready),
    .m_axis_mac_data(b_md), .m_axis_mac_user(b_mu), .m_axis_mac_keep(b_mk),
    .m_axis_mac_last(b_ml), .m_axis_mac_valid(b_mv), .m_axis_mac_ready(m_ready),
    .o_overrun(b_ovr)
  );

  int     vectors = 0;
  int     miscompares = 0;
  int     rst_cnt = 0;
  int     arp_idx = 0;
  int     ip_idx = 0;
  int     cyc = 0;
  bit     mr_mode = 0;
  beat_t  arp_q[$];
  beat_t  ip_q[$];
  beat_t  out_q[$];
  trace_t trace[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source/sink models: drive on the falling edge, record the cycle just before
  // the rising edge when everything is stable.
  initial begin
    i_rst = 1'b1;
    sel = 1'b0;
    arp_valid = 1'b0; arp_data = '0; arp_user = '0; arp_keep = '0; arp_last = 1'b0;
    ip_valid  = 1'b0; ip_data  = '0; ip_user  = '0; ip_keep  = '0; ip_last  = 1'b0;
    m_ready = 1'b0;
    forever begin
      trace_t tr;
      @(negedge clk);
      i_rst = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if (arp_idx < arp_q.size()) begin
        {arp_data, arp_user, arp_keep, arp_last} = arp_q[arp_idx];
        arp_valid = 1'b1;
      end else begin
        {arp_data, arp_user, arp_keep, arp_last} = '0;
        arp_valid = 1'b0;
      end
      if (ip_idx < ip_q.size()) begin
        {ip_data, ip_user, ip_keep, ip_last} = ip_q[ip_idx];
        ip_valid = 1'b1;
      end else begin
        {ip_data, ip_user, ip_keep, ip_last} = '0;
        ip_valid = 1'b0;
      end
      m_ready = mr_mode ? cyc[0] : 1'b1;
      #1;
      tr.av = arp_valid; tr.ar = arp_ready; tr.iv = ip_valid; tr.ir = ip_ready;
      tr.mv = mv; tr.mr = m_ready; tr.ov = ovr; tr.ob = {md, mu, mk, ml};
      trace.push_back(tr);
      if (mv && m_ready) out_q.push_back({md, mu, mk, ml});
      if (arp_valid && arp_ready) arp_idx++;
      if (ip_valid && ip_ready) ip_idx++;
      cyc++;
    end
  end

  function automatic beat_t mk_beat(int src, int f, int b, int n);
    beat_t x;
    x.d = {(src == 0) ? 4'hA : 4'hB, 12'(f), 16'(b), 32'h5A5A_0000 ^ 32'(b * 17 + f * 3)};
    x.u = {16'(f * 7 + b + src * 256), x.d};
    x.k = (b == n - 1) ? 8'h03 : 8'hFF;
    x.l = (b == n - 1);
    return x;
  endfunction

  task automatic push_frame(input int src, input int f, input int n);
    for (int b = 0; b < n; b++) begin
      if (src == 0) arp_q.push_back(mk_beat(src, f, b, n));
      else          ip_q.push_back(mk_beat(src, f, b, n));
    end
  endtask

  task automatic reset_all(input bit s);
    sel = s;
    arp_q.delete(); ip_q.delete();
    arp_idx = 0; ip_idx = 0;
    mr_mode = 0;
    rst_cnt = 2;
    repeat (4) @(posedge clk);
    #2;
    out_q.delete(); trace.delete();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (arp_idx == arp_q.size() && ip_idx == ip_q.size() && !mv) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_cnt = 6;
    push_frame(0, 0, 2);
    push_frame(1, 0, 2);
    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if (mv !== 1'b0) begin miscompares++; $display("FAIL reset_valid inst%0d got %b want 0", s, mv); end
      vectors++;
      if ({md, mu, mk, ml} !== '0) begin miscompares++; $display("FAIL reset_payload inst%0d got %h want 0", s, {md, mu, mk, ml}); end
      vectors++;
      if ({arp_ready, ip_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readies inst%0d got %b want 00", s, {arp_ready, ip_ready}); end
      vectors++;
      if (ovr !== 1'b0) begin miscompares++; $display("FAIL reset_overrun inst%0d got %b want 0", s, ovr); end
    end
    sel = 1'b0;
    vectors++;
    if (arp_idx != 0 || ip_idx != 0) begin
      miscompares++; $display("FAIL reset_no_accept got arp=%0d ip=%0d want 0 0", arp_idx, ip_idx);
    end
  endtask

  task automatic test_arp_only();
    bit ok;
    int t_v, t_a, t_o;
    beat_t exp, act;
    reset_all(0);
    push_frame(0, 0, 6);
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL arp_only_timeout got busy want idle"); end
    vectors++;
    if (out_q.size() != 6) begin miscompares++; $display("FAIL arp_only_count got %0d want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      exp = mk_beat(0, 0, i, 6);
      act = (i < out_q.size()) ? out_q[i] : '0;
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL arp_only_beat%0d got %h want %h", i, act, exp); end
    end
    t_v = -1; t_a = -1; t_o = -1;
    for (int t = 0; t < trace.size(); t++) begin
      if (t_v < 0 && trace[t].av) t_v = t;
      if (t_a < 0 && trace[t].av && trace[t].ar) t_a = t;
      if (t_o < 0 && trace[t].mv) t_o = t;
    end
    vectors++;
    if (t_v < 0 || trace[t_v].ar !== 1'b0) begin
      miscompares++; $display("FAIL arp_ready_in_idle got first_valid_cycle=%0d ready_high want ready 0", t_v);
    end
    vectors++;
    if (t_a != t_v + 1) begin miscompares++; $display("FAIL arp_grant_delay got accept@%0d want %0d", t_a, t_v + 1); end
    vectors++;
    if (t_o != t_a + 1) begin miscompares++; $display("FAIL arp_latency got out@%0d want %0d", t_o, t_a + 1); end
  endtask

  task automatic test_priority();
    bit ok;
    int t_l, n_acc, t_alast, n_ir;
    beat_t exp, act;
    reset_all(0);
    push_frame(1, 0, 3);
    push_frame(0, 0, 4);
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL prio_timeout got busy want idle"); end
    vectors++;
    if (out_q.size() != 7) begin miscompares++; $display("FAIL prio_count got %0d want 7", out_q.size()); end
    for (int i = 0; i < 7; i++) begin
      exp = (i < 4) ? mk_beat(0, 0, i, 4) : mk_beat(1, 0, i - 4, 3);
      act = (i < out_q.size()) ? out_q[i] : '0;
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL prio_beat%0d got %h want %h", i, act, exp); end
    end
    n_acc = 0; t_alast = -1; t_l = -1;
    for (int t = 0; t < trace.size(); t++) begin
      if (trace[t].av && trace[t].ar) begin
        n_acc++;
        if (n_acc == 4) t_alast = t;
      end
      if (t_l < 0 && trace[t].mv && trace[t].mr && trace[t].ob.l) t_l = t;
    end
    n_ir = 0;
    for (int t = 0; t <= t_alast; t++) if (trace[t].ir) n_ir++;
    vectors++;
    if (t_alast < 0 || n_ir != 0) begin
      miscompares++; $display("FAIL prio_ip_ready_held got %0d high cycles (arp_end=%0d) want 0", n_ir, t_alast);
    end
    vectors++;
    if (t_l < 0 || t_l + 2 >= trace.size() || trace[t_l + 1].mv !== 1'b0 || trace[t_l + 2].mv !== 1'b1) begin
      miscompares++; $display("FAIL prio_bubble got last@%0d (no single idle gap) want one bubble", t_l);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    beat_t exp, act;
    reset_all(1);
    for (int f = 0; f < 4; f++) begin
      push_frame(0, f, 3);
      push_frame(1, f, 3);
    end
    wait_idle(400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_timeout got busy want idle"); end
    vectors++;
    if (out_q.size() != 24) begin miscompares++; $display("FAIL rr_count got %0d want 24", out_q.size()); end
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 3; b++) begin
        exp = mk_beat(k % 2, k / 2, b, 3);
        act = (k * 3 + b < out_q.size()) ? out_q[k * 3 + b] : '0;
        vectors++;
        if (act !== exp) begin miscompares++; $display("FAIL rr_frame%0d_beat%0d got %h want %h", k, b, act, exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n_hold;
    beat_t exp, act;
    reset_all(0);
    mr_mode = 1;
    push_frame(1, 0, 10);
    wait_idle(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_timeout got busy want idle"); end
    vectors++;
    if (out_q.size() != 10) begin miscompares++; $display("FAIL bp_count got %0d want 10", out_q.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = mk_beat(1, 0, i, 10);
      act = (i < out_q.size()) ? out_q[i] : '0;
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL bp_beat%0d got %h want %h", i, act, exp); end
    end
    n_hold = 0;
    for (int t = 0; t + 1 < trace.size(); t++) begin
      if (trace[t].mv && !trace[t].mr) begin
        n_hold++;
        vectors++;
        if (trace[t + 1].mv !== 1'b1 || trace[t + 1].ob !== trace[t].ob) begin
          miscompares++; $display("FAIL bp_hold@%0d got v=%b %h want v=1 %h", t, trace[t + 1].mv, trace[t + 1].ob, trace[t].ob);
        end
      end
    end
    vectors++;
    if (n_hold == 0) begin miscompares++; $display("FAIL bp_hold_seen got 0 stalled cycles want >0"); end
  endtask

  task automatic test_overrun();
    bit ok;
    int n_ovr, t_ov;
    beat_t exp_q[$];
    beat_t exp, act;
    reset_all(1);
    push_frame(1, 0, 7);
    push_frame(1, 1, 2);
    for (int i = 0; i < 4; i++) begin
      exp = mk_beat(1, 0, i, 7);
      if (i == 3) exp.l = 1'b1;
      exp_q.push_back(exp);
    end
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_beat(1, 1, i, 2));
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovr_timeout got busy want idle"); end
    vectors++;
    if (ip_idx != 9) begin miscompares++; $display("FAIL ovr_consumed got %0d want 9", ip_idx); end
    vectors++;
    if (out_q.size() != 6) begin miscompares++; $display("FAIL ovr_count got %0d want 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      act = (i < out_q.size()) ? out_q[i] : '0;
      vectors++;
      if (act !== exp_q[i]) begin miscompares++; $display("FAIL ovr_beat%0d got %h want %h", i, act, exp_q[i]); end
    end
    n_ovr = 0; t_ov = -1;
    for (int t = 0; t < trace.size(); t++) begin
      if (trace[t].ov) begin
        n_ovr++;
        if (t_ov < 0) t_ov = t;
      end
    end
    vectors++;
    if (n_ovr != 1) begin miscompares++; $display("FAIL ovr_pulse_count got %0d want 1", n_ovr); end
    vectors++;
    if (t_ov < 0 || trace[t_ov].mv !== 1'b1 || trace[t_ov].ob !== exp_q[3]) begin
      miscompares++; $display("FAIL ovr_pulse_align got cycle %0d want aligned with forced-last beat", t_ov);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n_last;
    beat_t exp, act;
    reset_all(0);
    push_frame(0, 0, 6);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #2;
      if (arp_idx >= 3) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_reach_beat3 got %0d accepted want 3", arp_idx); end
    rst_cnt = 1;
    @(posedge clk); #2;
    vectors++;
    if (mv !== 1'b0 || ml !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got v=%b l=%b want 0 0", mv, ml); end
    vectors++;
    if ({arp_ready, ip_ready} !== 2'b00) begin miscompares++; $display("FAIL rstmid_readies got %b want 00", {arp_ready, ip_ready}); end
    n_last = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i].l) n_last++;
    vectors++;
    if (out_q.size() != 3 || n_last != 0) begin
      miscompares++; $display("FAIL rstmid_partial got %0d beats %0d lasts want 3 beats 0 lasts", out_q.size(), n_last);
    end
    arp_q.delete();
    arp_idx = 0;
    @(negedge clk); #2;
    vectors++;
    if (mv !== 1'b0 || {arp_ready, ip_ready} !== 2'b00) begin
      miscompares++; $display("FAIL rstmid_after got v=%b rdy=%b want 0 00", mv, {arp_ready, ip_ready});
    end
    @(posedge clk); #2;
    out_q.delete(); trace.delete();
    push_frame(0, 1, 3);
    wait_idle(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_new_timeout got busy want idle"); end
    vectors++;
    if (out_q.size() != 3) begin miscompares++; $display("FAIL rstmid_new_count got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3; i++) begin
      exp = mk_beat(0, 1, i, 3);
      act = (i < out_q.size()) ? out_q[i] : '0;
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL rstmid_new_beat%0d got %h want %h", i, act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_arp_only();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
